// File: rtl/draw_manager.sv
// draw_manager: arbitrates the shared pixel write bus among draw
// sources and forwards clipped pixels to the framebuffer.
module draw_manager #(
   parameter int NUM_SOURCES = 4,
   parameter int COLOR_DEPTH = 9,
   parameter int DRAW_WIDTH  = 640,
   parameter int DRAW_HEIGHT = 480,
   parameter int TIMEOUT     = 1023,
   localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
   localparam int FB_AW = $clog2(DRAW_WIDTH * DRAW_HEIGHT)
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    frame,
   output logic [SRC_W-1:0]        write_source_sel,
   output logic                    write_awaited,
   input  logic                    write_active,
   input  logic [COLOR_DEPTH-1:0]  write_color_data,
   input  logic                    write_transparent,
   input  logic signed [31:0]      write_x_addr,
   input  logic signed [31:0]      write_y_addr,
   output logic                    fb_we,
   output logic [FB_AW-1:0]        fb_addr,
   output logic [COLOR_DEPTH-1:0]  fb_data,
   output logic                    fb_swap,
   output logic                    busy,
   output logic                    overrun
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_DRAW,
      S_NEXT,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [SRC_W-1:0]   idx;
   logic [CNT_W-1:0]   cnt;
   logic               last_src;
   logic               cnt_expired;
   logic               granted;
   logic               accept;
   logic               in_range;
   logic               do_write;
   logic [FB_AW-1:0]   lin_addr;

   assign last_src    = (idx == SRC_W'(NUM_SOURCES - 1));
   assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));
   assign granted     = (state == S_GRANT) || (state == S_DRAW);
   assign accept      = granted && write_active;

   // Signed bounds check: negative coordinates must be clipped.
   assign in_range = (write_x_addr >= 0) &&
                     (write_x_addr < DRAW_WIDTH) &&
                     (write_y_addr >= 0) &&
                     (write_y_addr < DRAW_HEIGHT);

   assign do_write = accept && !write_transparent && in_range;

   // Full-width linear address, truncated to the framebuffer width.
   assign lin_addr = FB_AW'(write_y_addr * DRAW_WIDTH + write_x_addr);

   assign write_source_sel = idx;

   // State register.
   always_ff @(posedge clk) begin
      if (!resetN)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; a pixel in the timeout cycle still wins.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (frame) state_nxt = S_GRANT;
         S_GRANT: begin
            if (write_active)
               state_nxt = S_DRAW;
            else if (cnt_expired)
               state_nxt = S_NEXT;
         end
         S_DRAW:  if (!write_active) state_nxt = S_NEXT;
         S_NEXT:  state_nxt = last_src ? S_DONE : S_GRANT;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      write_awaited = granted;
      busy          = (state != S_IDLE);
      fb_swap       = (state == S_DONE);
   end

   // Source index: restarts at 0 per frame, advances only in NEXT.
   always_ff @(posedge clk) begin
      if (!resetN)
         idx <= '0;
      else if (state == S_IDLE && frame)
         idx <= '0;
      else if (state == S_NEXT && !last_src)
         idx <= idx + 1'b1;
      else if (state == S_DONE)
         idx <= '0;
   end

   // Idle counter runs only while a grant is waiting for pixels.
   always_ff @(posedge clk) begin
      if (!resetN)
         cnt <= '0;
      else if (state == S_GRANT)
         cnt <= cnt + 1'b1;
      else
         cnt <= '0;
   end

   // Sticky flag for frame pulses that arrive mid-pass.
   always_ff @(posedge clk) begin
      if (!resetN)
         overrun <= 1'b0;
      else if (frame && state != S_IDLE)
         overrun <= 1'b1;
   end

   // Registered framebuffer write port, one cycle after acceptance.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         fb_we <= do_write;
         if (do_write) begin
            fb_addr <= lin_addr;
            fb_data <= write_color_data;
         end
      end
   end

endmodule

// File: tb/tb_draw_manager.sv
// tb_draw_manager: directed stimulus with a write scoreboard
// popped by an independent framebuffer monitor.
module tb_draw_manager;

   localparam int NS = 4;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        resetN;
   logic        frame;
   logic [1:0]  write_source_sel;
   logic        write_awaited;
   logic        write_active;
   logic [8:0]  write_color_data;
   logic        write_transparent;
   logic [31:0] write_x_addr;
   logic [31:0] write_y_addr;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [8:0]  fb_data;
   logic        fb_swap;
   logic        busy;
   logic        overrun;

   typedef struct {
      logic [18:0] addr;
      logic [8:0]  data;
      int          cyc;
   } wr_t;

   wr_t exp_q[$];
   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  swap_cnt = 0;

   draw_manager #(
      .NUM_SOURCES(NS),
      .COLOR_DEPTH(9),
      .DRAW_WIDTH(640),
      .DRAW_HEIGHT(480),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .frame(frame),
      .write_source_sel(write_source_sel),
      .write_awaited(write_awaited),
      .write_active(write_active),
      .write_color_data(write_color_data),
      .write_transparent(write_transparent),
      .write_x_addr(write_x_addr),
      .write_y_addr(write_y_addr),
      .fb_we(fb_we),
      .fb_addr(fb_addr),
      .fb_data(fb_data),
      .fb_swap(fb_swap),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every framebuffer write must match the next expected one.
   always @(negedge clk) begin
      if (fb_swap) swap_cnt++;
      if (fb_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {13'd0, fb_addr}, 64'hFFFFFFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("fb_addr", fb_addr, e.addr);
            chk("fb_data", fb_data, e.data);
            chk("fb_latency", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_frame();
      frame = 1'b1;
      tick();
      frame = 1'b0;
   endtask

   task automatic wait_grant(input int s);
      bit found = 0;
      for (int i = 0; i < 60; i++) begin
         if (write_awaited && write_source_sel == 2'(s)) begin
            found = 1;
            break;
         end
         tick();
      end
      chk($sformatf("grant_src%0d", s), found, 1);
   endtask

   task automatic send_pix(input logic [31:0] x,
                           input logic [31:0] y,
                           input logic [8:0]  c,
                           input logic        tr,
                           input logic [18:0] ea);
      wr_t e;
      write_active      = 1'b1;
      write_x_addr      = x;
      write_y_addr      = y;
      write_color_data  = c;
      write_transparent = tr;
      if (ea != '1) begin
         e.addr = ea;
         e.data = c;
         e.cyc  = cyc + 1;
         exp_q.push_back(e);
      end
      tick();
   endtask

   task automatic end_burst();
      write_active      = 1'b0;
      write_transparent = 1'b0;
      tick();
   endtask

   task automatic count_timeout(input int s);
      int n = 0;
      wait_grant(s);
      while (write_awaited && n < 30) begin
         n++;
         tick();
      end
      chk($sformatf("timeout_len_src%0d", s), n, TO);
   endtask

   task automatic wait_swap();
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
         if (fb_swap) begin
            found = 1;
            break;
         end
         tick();
      end
      chk("swap_seen", found, 1);
      chk("busy_at_swap", busy, 1);
      tick();
      chk("swap_one_cycle", fb_swap, 0);
      chk("busy_after_swap", busy, 0);
   endtask

   task automatic do_reset();
      resetN       = 1'b0;
      frame        = 1'b0;
      write_active = 1'b0;
      tick();
      tick();
      resetN = 1'b1;
   endtask

   localparam logic [18:0] NOWR = '1;

   initial begin
      int sc;
      resetN            = 1'b0;
      frame             = 1'b0;
      write_active      = 1'b0;
      write_color_data  = '0;
      write_transparent = 1'b0;
      write_x_addr      = '0;
      write_y_addr      = '0;

      // Reset state
      do_reset();
      chk("reset_outputs",
          {fb_we, write_awaited, busy, write_source_sel,
           fb_swap, overrun, fb_addr, fb_data},
          0);

      // Pixels offered while idle are ignored
      write_active = 1'b1;
      tick();
      tick();
      chk("idle_no_grant", write_awaited, 0);
      write_active = 1'b0;
      tick();

      // Frame 1: src0 three pixels plus three dropped ones
      pulse_frame();
      chk("busy_after_frame", busy, 1);
      wait_grant(0);
      send_pix(10, 0, 9'h1FF, 0, 19'd10);
      send_pix(20, 1, 9'h1FF, 0, 19'd660);
      send_pix(639, 479, 9'h1FF, 0, 19'd307199);
      send_pix(50, 50, 9'h0A5, 1, NOWR);
      send_pix(32'hFFFFFFFF, 0, 9'h0A5, 0, NOWR);
      send_pix(0, 480, 9'h0A5, 0, NOWR);
      chk("draw_kept_grant", {write_awaited, write_source_sel}, 3'b100);
      end_burst();
      chk("next_gap", {write_awaited, write_source_sel}, 3'b000);
      tick();
      chk("src1_after_gap", {write_awaited, write_source_sel}, 3'b101);
      send_pix(5, 5, 9'h0AA, 0, 19'd3205);
      end_burst();
      count_timeout(2);
      count_timeout(3);
      sc = swap_cnt;
      wait_swap();
      chk("frame1_swaps", swap_cnt - sc, 1);

      // Frame 2: src0 times out, src1 draws
      pulse_frame();
      count_timeout(0);
      wait_grant(1);
      send_pix(1, 0, 9'h123, 0, 19'd1);
      end_burst();
      wait_swap();
      chk("no_overrun_yet", overrun, 0);

      // Frame 3: second frame pulse in the middle of a draw
      sc = swap_cnt;
      pulse_frame();
      wait_grant(0);
      send_pix(30, 2, 9'h011, 0, 19'd1310);
      frame = 1'b1;
      send_pix(31, 2, 9'h022, 0, 19'd1311);
      frame = 1'b0;
      chk("overrun_set", overrun, 1);
      chk("busy_kept", busy, 1);
      send_pix(32, 2, 9'h033, 0, 19'd1312);
      end_burst();
      wait_swap();
      for (int i = 0; i < 20; i++) tick();
      chk("single_swap", swap_cnt - sc, 1);
      chk("overrun_sticky", overrun, 1);

      // Frame 4: reset lands mid-draw with a pixel presented
      pulse_frame();
      wait_grant(0);
      send_pix(1, 1, 9'h055, 0, 19'd641);
      resetN = 1'b0;
      send_pix(2, 2, 9'h066, 0, NOWR);
      chk("reset_mid_draw",
          {fb_we, write_awaited, busy, write_source_sel,
           fb_swap, overrun, fb_addr, fb_data},
          0);
      resetN = 1'b1;
      end_burst();
      pulse_frame();
      chk("restart_src0", {write_awaited, write_source_sel}, 3'b100);
      send_pix(3, 0, 9'h0F0, 0, 19'd3);
      end_burst();
      wait_swap();

      // Frame 5: four sources with one pixel each
      pulse_frame();
      for (int s = 0; s < NS; s++) begin
         wait_grant(s);
         send_pix(s, 10, 9'(s + 1), 0, 19'(6400 + s));
         end_burst();
      end
      wait_swap();

      for (int i = 0; i < 4; i++) tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/draw_manager.md
DRAW_MANAGER -- requirements
Module: draw_manager

Interface
REQ-001 Parameter NUM_SOURCES, default 4: number of draw sources sharing the write bus, served in ID order 0..NUM_SOURCES-1.
REQ-002 Parameter COLOR_DEPTH, default 9: pixel color width.
REQ-003 Parameter DRAW_WIDTH, default 640: framebuffer width in pixels.
REQ-004 Parameter DRAW_HEIGHT, default 480: framebuffer height in pixels.
REQ-005 Parameter TIMEOUT, default 1023: idle cycles allowed per source before it is skipped.
REQ-006 Derived constants: SRC_W = max(1, clog2(NUM_SOURCES)); FB_AW = clog2(DRAW_WIDTH*DRAW_HEIGHT).
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 resetN  input  1  synchronous, active-low reset.
REQ-009 frame  input  1  one-cycle pulse marking start of a frame's draw pass.
REQ-010 write_source_sel  output  SRC_W  ID of the source currently owning the shared write bus.
REQ-011 write_awaited  output  1  grant: manager is ready to accept pixels from the selected source.
REQ-012 write_active  input  1  selected source presents a valid pixel this cycle; undriven (z) reads as 0.
REQ-013 write_color_data  input  COLOR_DEPTH  pixel color from selected source.
REQ-014 write_transparent  input  1  pixel is to be discarded.
REQ-015 write_x_addr  input  32  pixel column, signed.
REQ-016 write_y_addr  input  32  pixel row, signed.
REQ-017 fb_we  output  1  framebuffer write strobe.
REQ-018 fb_addr  output  FB_AW  linear address y*DRAW_WIDTH+x.
REQ-019 fb_data  output  COLOR_DEPTH  pixel color written.
REQ-020 fb_swap  output  1  one-cycle pulse when all sources finished for the frame.
REQ-021 busy  output  1  high from accepted frame pulse until fb_swap.
REQ-022 overrun  output  1  sticky; set when frame arrives while busy.

Function
REQ-023 FSM states: IDLE, GRANT, DRAW, NEXT, DONE.
REQ-024 IDLE: write_awaited=0; on frame=1 -> GRANT with source index 0, busy=1.
REQ-025 GRANT: write_awaited=1, write_source_sel=index; timeout counter increments each cycle; write_active=1 -> DRAW (that pixel is accepted); counter reaching TIMEOUT -> NEXT.
REQ-026 DRAW: write_awaited=1; every cycle with write_active=1 is one accepted pixel; first cycle with write_active=0 -> NEXT.
REQ-027 NEXT: write_awaited=0 for exactly one cycle; index < NUM_SOURCES-1 -> increment, clear counter, GRANT; else -> DONE.
REQ-028 DONE: fb_swap=1 for one cycle, busy=0 next cycle, -> IDLE.
REQ-029 Accepted pixel is written only if write_transparent=0 and 0<=x<DRAW_WIDTH and 0<=y<DRAW_HEIGHT (signed compare); otherwise dropped silently.
REQ-030 Write latency: fb_we/fb_addr/fb_data registered, asserted exactly one cycle after the accepting cycle; fb_we=0 in all other cycles.
REQ-031 fb_addr computed full-width then truncated to FB_AW; no wrap beyond DRAW_WIDTH*DRAW_HEIGHT-1 for legal x,y.
REQ-032 write_source_sel holds its value through NEXT until incremented; never changes while write_awaited=1.
REQ-033 frame while busy: ignored, overrun set; frame in same cycle as DONE: ignored, overrun set.
REQ-034 write_active seen while in IDLE, NEXT or DONE: ignored, no write.
REQ-035 NUM_SOURCES=1: NEXT goes directly to DONE.
REQ-036 A source back-to-back re-asserting write_active after deasserting in the same grant is not served; its pixels are lost until next frame.

Reset
REQ-037 resetN=0 on any edge, including mid-DRAW: state=IDLE, index=0, counter=0, write_source_sel=0, write_awaited=0, fb_we=0, fb_addr=0, fb_data=0, fb_swap=0, busy=0, overrun=0.
REQ-038 A pixel accepted in the cycle reset is asserted is not written.

Verification
REQ-039 2 sources, frame pulse; src0 drives 3 pixels (10,0),(20,1),(639,479) color 0x1FF -> fb_we 3 cycles, fb_addr 10, 660, 307199; then src1 granted after one idle cycle.
REQ-040 Pixel with write_transparent=1, then x=-1, then y=480 -> accepted, fb_we stays 0, FSM behaviour unchanged.
REQ-041 TIMEOUT=8, src0 never asserts write_active -> write_awaited high 8 cycles, then sel=1 granted; fb_swap after src1 completes.
REQ-042 Second frame pulse during src0 DRAW -> overrun=1, pass continues, single fb_swap.
REQ-043 resetN=0 during DRAW with write_active=1 -> next cycle all outputs zero, no fb_we; new frame restarts at source 0.
REQ-044 4 sources each 1 pixel -> fb_swap exactly 1 cycle, busy falls the cycle after, write_source_sel sequence 0,1,2,3.
